fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS core.
- Holds the PC and issues one instruction-memory request at a time over a ready/valid handshake.
- Delivers instr_d / pcplus4_d / valid_d to the decode stage, where the main and ALU decoders consume op/funct.
- Supports hazard-unit stall and flush, plus branch/jump redirect from decode.

---
 rtl/fetch_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus IF/ID pipeline register.
// Keeps the fetch PC and issues one instruction-memory request at a time.
// Responses go to decode. If decode is stalled, a response goes to a one-entry hold buffer.
// Optional build macro: FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
//
// Handshake: a request is accepted when imem_req && imem_ready are both high
// in the same cycle. The response is marked by imem_rvalid no earlier than the
// next cycle. At most one request is outstanding.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt,
`endif
  output logic [1:0]  o_dbg_state
);

  // FETCH: may issue a request. WAIT: a live request is outstanding.
  // DROP: the outstanding response belongs to a squashed path.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_pc_f;
  logic [31:0] r_req_pc;

  logic        r_hold_valid;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;

  logic [31:0] r_instr_d;
  logic [31:0] r_pcplus4_d;
  logic        r_valid_d;

  logic        w_fetch_req;
  logic        w_accept;
  logic        w_rv_wait;
  logic        w_avail;
  logic [31:0] w_avail_instr;
  logic [31:0] w_avail_pc;
  logic [31:0] w_redirect_pc;
  logic        w_ifid_load;
  logic        w_ifid_bubble;
  logic        w_hold_capture;
  logic        w_hold_clear;
  logic        w_unused;

  // Targets are always word aligned. The low two bits of redirect_pc are dropped.
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused      = ^redirect_pc[1:0];

  // Request only from FETCH. A pending hold buffer entry blocks new requests.
  assign w_fetch_req = !reset && (r_state == S_FETCH) && !r_hold_valid;
  assign w_accept    = w_fetch_req && imem_ready;
  assign imem_req    = w_fetch_req;
  assign imem_addr   = r_pc_f;

  // A response is live only in WAIT. An rvalid in FETCH is stale and is ignored.
  assign w_rv_wait     = (r_state == S_WAIT) && imem_rvalid;
  assign w_avail       = r_hold_valid || w_rv_wait;
  assign w_avail_instr = r_hold_valid ? r_hold_instr : imem_rdata;
  assign w_avail_pc    = r_hold_valid ? r_hold_pc    : r_req_pc;

  assign o_dbg_state = r_state;

  // Next-state logic for the request/response tracker
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: begin
        // An accepted request that coincides with a redirect is already stale
        if (w_accept) begin
          w_state_next = redirect_valid ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_state_next = S_FETCH;
        end else if (redirect_valid) begin
          w_state_next = S_DROP;
        end
      end
      S_DROP: begin
        // The squashed response closes the transaction, even with a redirect
        // in the same cycle. Nothing else is outstanding, so waiting longer
        // would never end.
        if (imem_rvalid) begin
          w_state_next = S_FETCH;
        end
      end
      default: w_state_next = S_FETCH;
    endcase
  end

  // Decide what the IF/ID register and hold buffer do this cycle.
  // Priority order: redirect, then flush, then stall.
  always_comb begin
    w_ifid_load    = 1'b0;
    w_ifid_bubble  = 1'b0;
    w_hold_capture = 1'b0;
    w_hold_clear   = 1'b0;
    if (redirect_valid) begin
      w_hold_clear  = 1'b1;
      w_ifid_bubble = !stall_d;
    end else if (flush_d) begin
      w_hold_clear  = 1'b1;
      w_ifid_bubble = 1'b1;
    end else if (stall_d) begin
      w_hold_capture = w_rv_wait;
    end else if (w_avail) begin
      w_ifid_load  = 1'b1;
      w_hold_clear = 1'b1;
    end else begin
      w_ifid_bubble = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Fetch PC and the PC of the outstanding request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_f   <= RESET_PC;
      r_req_pc <= 32'h0000_0000;
    end else begin
      if (redirect_valid) begin
        r_pc_f <= w_redirect_pc;
      end else if (w_accept) begin
        r_pc_f <= r_pc_f + 32'd4;
      end
      if (w_accept) begin
        r_req_pc <= r_pc_f;
      end
    end
  end

  // One-entry hold buffer, used while decode is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_valid <= 1'b0;
      r_hold_instr <= 32'h0000_0000;
      r_hold_pc    <= 32'h0000_0000;
    end else if (w_hold_capture) begin
      r_hold_valid <= 1'b1;
      r_hold_instr <= imem_rdata;
      r_hold_pc    <= r_req_pc;
    end else if (w_hold_clear) begin
      r_hold_valid <= 1'b0;
    end
  end

  // IF/ID pipeline register. It holds its value unless it loads an instruction or a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_d   <= 32'h0000_0000;
      r_pcplus4_d <= 32'h0000_0000;
      r_valid_d   <= 1'b0;
    end else if (w_ifid_load) begin
      r_instr_d   <= w_avail_instr;
      r_pcplus4_d <= w_avail_pc + 32'd4;
      r_valid_d   <= 1'b1;
    end else if (w_ifid_bubble) begin
      r_instr_d   <= 32'h0000_0000;
      r_pcplus4_d <= 32'h0000_0000;
      r_valid_d   <= 1'b0;
    end
  end

  assign instr_d   = r_instr_d;
  assign pcplus4_d = r_pcplus4_d;
  assign valid_d   = r_valid_d;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_bubble_cnt;

  // Saturating counts of instructions and bubbles loaded into IF/ID
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetch_cnt  <= 32'h0000_0000;
      r_perf_bubble_cnt <= 32'h0000_0000;
    end else begin
      if (w_ifid_load && (r_perf_fetch_cnt != 32'hFFFF_FFFF)) begin
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      end
      if (w_ifid_bubble && (r_perf_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt  = r_perf_fetch_cnt;
  assign perf_bubble_cnt = r_perf_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed table of per-cycle vectors, wrap-around check on a
// second instance with RESET_PC=FFFF_FFFC, and randomized traffic against a
// transaction-level reference model.
module tb_fetch_stage;

  localparam int N_RAND = 4000;

  // ---------------- clock / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        stall_d = 1'b0, flush_d = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, valid_d;
  logic [31:0] imem_addr, instr_d, pcplus4_d;
  logic [1:0]  dbg_state;

  logic        b_reset = 1'b1, b_ready = 1'b0, b_rvalid = 1'b0;
  logic [31:0] b_rdata = '0;
  logic        b_req, b_valid;
  logic [31:0] b_addr, b_instr, b_pc4;
  logic [1:0]  b_dbg;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt, b_pf, b_pb;
`endif

  fetch_stage u_dut (
    .clk(clk), .reset(reset), .stall_d(stall_d), .flush_d(flush_d),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt),
`endif
    .o_dbg_state(dbg_state)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .reset(b_reset), .stall_d(1'b0), .flush_d(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ready(b_ready),
    .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
    .instr_d(b_instr), .pcplus4_d(b_pc4), .valid_d(b_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt(b_pf), .perf_bubble_cnt(b_pb),
`endif
    .o_dbg_state(b_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, stall, flush, redir;
    logic [31:0] rpc;
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_pc4;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rst, stall, flush, redir, input logic [31:0] rpc,
                     input logic rdy, rv, input logic [31:0] rdata,
                     input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_instr, e_pc4);
    vec_t v;
    v = '{rst, stall, flush, redir, rpc, rdy, rv, rdata, e_req, e_addr, e_valid, e_instr, e_pc4};
    tv.push_back(v);
  endtask

  // Inputs applied for one cycle. The request is checked before the edge and IF/ID after it.
  task automatic run_vec(input int idx, input vec_t v);
    reset = v.rst; stall_d = v.stall; flush_d = v.flush;
    redirect_valid = v.redir; redirect_pc = v.rpc;
    imem_ready = v.rdy; imem_rvalid = v.rv; imem_rdata = v.rdata;
    @(negedge clk);
    check($sformatf("vec%0d imem_req", idx), {31'b0, imem_req}, {31'b0, v.e_req});
    if (v.e_req) check($sformatf("vec%0d imem_addr", idx), imem_addr, v.e_addr);
    @(posedge clk);
    #1;
    check($sformatf("vec%0d valid_d", idx), {31'b0, valid_d}, {31'b0, v.e_valid});
    check($sformatf("vec%0d instr_d", idx), instr_d, v.e_instr);
    if (v.e_valid) check($sformatf("vec%0d pcplus4_d", idx), pcplus4_d, v.e_pc4);
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } hold_t;

  logic [31:0] m_pc, m_req_pc, m_instr, m_pc4;
  logic        m_valid;
  bit          m_inflight, m_squash;
  hold_t       m_hold[$];
  longint      m_fcnt, m_bcnt;

  task automatic m_bubble();
    m_valid = 1'b0; m_instr = '0; m_fcnt = m_fcnt;
    m_bcnt++;
  endtask

  task automatic m_load(input logic [31:0] instr, input logic [31:0] pc);
    m_valid = 1'b1; m_instr = instr; m_pc4 = pc + 32'd4;
    m_fcnt++;
  endtask

  // Apply one clock edge. The current input values drive the model.
  task automatic model_step(input bit req);
    bit    accept, got, live, avail;
    hold_t h;
    if (reset) begin
      m_pc = 32'h0; m_inflight = 0; m_squash = 0; m_hold.delete();
      m_valid = 0; m_instr = '0; m_pc4 = '0; m_fcnt = 0; m_bcnt = 0;
      return;
    end
    accept = req && imem_ready;
    got    = m_inflight && imem_rvalid;
    live   = got && !m_squash;
    avail  = (m_hold.size() != 0) || live;
    if (redirect_valid) begin
      m_hold.delete();
      if (!stall_d) m_bubble();
    end else if (flush_d) begin
      m_hold.delete();
      m_bubble();
    end else if (stall_d) begin
      if (live) begin
        h.instr = imem_rdata; h.pc = m_req_pc;
        m_hold.push_back(h);
      end
    end else if (avail) begin
      if (m_hold.size() != 0) begin
        h = m_hold.pop_front();
        m_load(h.instr, h.pc);
      end else begin
        m_load(imem_rdata, m_req_pc);
      end
    end else begin
      m_bubble();
    end
    if (accept) begin
      m_inflight = 1; m_squash = redirect_valid; m_req_pc = m_pc;
    end else if (got) begin
      m_inflight = 0; m_squash = 0;
    end else if (redirect_valid && m_inflight) begin
      m_squash = 1;
    end
    if (redirect_valid) m_pc = {redirect_pc[31:2], 2'b00};
    else if (accept)    m_pc = m_pc + 32'd4;
  endtask

  // Contents of the random-phase memory
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit          mem_pending;
    int          mem_cnt;
    logic [31:0] mem_addr;
    bit          env_req, m_req;
    logic [31:0] env_addr;

    //   rst st fl rd rpc        rdy rv rdata          req addr        v  instr          pc4
    add(1, 0, 0, 0, 32'h0,     0, 0, 32'h0,          0, 32'h0,     0, 32'h0,          32'h0);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,          1, 32'h0,     0, 32'h0,          32'h0);
    add(0, 0, 0, 0, 32'h0,     0, 1, 32'h2008_0005,  0, 32'h0,     1, 32'h2008_0005,  32'h4);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,          1, 32'h4,     0, 32'h0,          32'h0);
    add(0, 0, 0, 0, 32'h0,     0, 0, 32'h0,          0, 32'h0,     0, 32'h0,          32'h0);
    add(0, 0, 0, 0, 32'h0,     0, 0, 32'h0,          0, 32'h0,     0, 32'h0,          32'h0);
    add(0, 0, 0, 0, 32'h0,     0, 1, 32'h8C01_0004,  0, 32'h0,     1, 32'h8C01_0004,  32'h8);
    add(0, 1, 0, 0, 32'h0,     1, 0, 32'h0,          1, 32'h8,     1, 32'h8C01_0004,  32'h8);
    add(0, 1, 0, 0, 32'h0,     0, 1, 32'h1109_0003,  0, 32'h0,     1, 32'h8C01_0004,  32'h8);
    add(0, 1, 0, 0, 32'h0,     1, 0, 32'h0,          0, 32'h0,     1, 32'h8C01_0004,  32'h8);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,          0, 32'h0,     1, 32'h1109_0003,  32'hC);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,          1, 32'hC,     0, 32'h0,          32'h0);
    add(0, 0, 0, 1, 32'h40,    0, 0, 32'h0,          0, 32'h0,     0, 32'h0,          32'h0);
    add(0, 0, 0, 0, 32'h0,     0, 1, 32'hDEAD_BEEF,  0, 32'h0,     0, 32'h0,          32'h0);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,          1, 32'h40,    0, 32'h0,          32'h0);
    add(0, 0, 0, 0, 32'h0,     0, 1, 32'h0800_0010,  0, 32'h0,     1, 32'h0800_0010,  32'h44);
    add(0, 1, 0, 0, 32'h0,     1, 0, 32'h0,          1, 32'h44,    1, 32'h0800_0010,  32'h44);
    add(0, 1, 1, 0, 32'h0,     0, 1, 32'h0123_4567,  0, 32'h0,     0, 32'h0,          32'h0);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,          1, 32'h48,    0, 32'h0,          32'h0);
    add(0, 0, 0, 0, 32'h0,     0, 1, 32'hAC02_0008,  0, 32'h0,     1, 32'hAC02_0008,  32'h4C);
    add(0, 0, 0, 1, 32'h103,   1, 0, 32'h0,          1, 32'h4C,    0, 32'h0,          32'h0);
    add(0, 0, 0, 0, 32'h0,     1, 1, 32'h1111_1111,  0, 32'h0,     0, 32'h0,          32'h0);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,          1, 32'h100,   0, 32'h0,          32'h0);
    add(0, 0, 0, 0, 32'h0,     0, 1, 32'h2222_2222,  0, 32'h0,     1, 32'h2222_2222,  32'h104);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,          1, 32'h104,   0, 32'h0,          32'h0);
    add(1, 0, 0, 0, 32'h0,     0, 0, 32'h0,          0, 32'h0,     0, 32'h0,          32'h0);
    add(0, 0, 0, 0, 32'h0,     0, 1, 32'h3333_3333,  1, 32'h0,     0, 32'h0,          32'h0);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,          1, 32'h0,     0, 32'h0,          32'h0);

    @(posedge clk);
    #1;
    foreach (tv[i]) run_vec(i, tv[i]);

    // ---- wrap-around instance: RESET_PC = FFFF_FFFC ----
    b_reset = 1'b1; b_ready = 1'b0; b_rvalid = 1'b0;
    @(posedge clk); #1;
    b_reset = 1'b0; b_ready = 1'b1;
    @(negedge clk);
    check("wrap first req", {31'b0, b_req}, 32'h1);
    check("wrap first addr", b_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    b_ready = 1'b0; b_rvalid = 1'b1; b_rdata = 32'h2008_0005;
    @(posedge clk); #1;
    check("wrap valid_d", {31'b0, b_valid}, 32'h1);
    check("wrap instr_d", b_instr, 32'h2008_0005);
    check("wrap pcplus4_d", b_pc4, 32'h0);
    b_rvalid = 1'b0; b_ready = 1'b1;
    @(negedge clk);
    check("wrap next addr", b_addr, 32'h0);
    @(posedge clk); #1;
    b_reset = 1'b1;

    // ---- randomized traffic against the reference model ----
    mem_pending = 0; mem_cnt = 0; mem_addr = '0;
    m_fcnt = 0; m_bcnt = 0;
    for (int i = 0; i < N_RAND; i++) begin
      reset          = (i == 0) || ($urandom_range(0, 499) == 0);
      stall_d        = ($urandom_range(0, 3) == 0);
      flush_d        = ($urandom_range(0, 11) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom();
      imem_ready     = ($urandom_range(0, 9) < 7);
      imem_rvalid    = mem_pending && (mem_cnt == 0);
      imem_rdata     = imem_rvalid ? mem_word(mem_addr) : $urandom();
      @(negedge clk);
      env_req  = imem_req;
      env_addr = imem_addr;
      m_req    = !reset && !m_inflight && (m_hold.size() == 0);
      check("rnd imem_req", {31'b0, env_req}, {31'b0, m_req});
      if (m_req) check("rnd imem_addr", env_addr, m_pc);
      @(posedge clk);
      model_step(m_req);
      if (reset) begin
        mem_pending = 0;
      end else begin
        if (imem_rvalid) mem_pending = 0;
        else if (mem_pending && mem_cnt > 0) mem_cnt--;
        if (env_req && imem_ready) begin
          mem_pending = 1;
          mem_cnt     = $urandom_range(0, 3);
          mem_addr    = env_addr;
        end
      end
      #1;
      check("rnd valid_d", {31'b0, valid_d}, {31'b0, m_valid});
      check("rnd instr_d", instr_d, m_instr);
      if (m_valid) check("rnd pcplus4_d", pcplus4_d, m_pc4);
`ifdef FETCH_PERF_CNT_EN
      check("rnd perf_fetch_cnt", perf_fetch_cnt, m_fcnt[31:0]);
      check("rnd perf_bubble_cnt", perf_bubble_cnt, m_bcnt[31:0]);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
